parking_count_sequencer: RTL

//   Shares one bit-serial full-adder datapath between the entry gate and the exit gate of the car park.

---
 rtl/parking_count_sequencer_pkg.sv | 27 ++
 rtl/parking_count_sequencer_serial_add_slice.sv | 61 ++++++
 rtl/parking_count_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/parking_count_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// parking_count_sequencer_pkg
//   Shared definitions for the car-park occupancy sequencer:
//     - FSM states (IDLE, ADD, DONE)
//     - operation codes (OP_INC / OP_DEC)
//     - requester identifiers (REQ_ENTRY / REQ_EXIT)
//   No ports; imported by parking_count_sequencer and serial_add_slice.
// ---------------------------------------------------------------------------
package parking_count_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_INC = 1'b0,
        OP_DEC = 1'b1
    } op_t;

    typedef enum logic {
        REQ_ENTRY = 1'b0,
        REQ_EXIT  = 1'b1
    } req_id_t;

endpackage

// File: rtl/parking_count_sequencer_serial_add_slice.sv
// ---------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full adder.
//   Ports: a, b, cin (in); sum, cout (out).
//
// serial_add_slice
//   One full_adder plus the registered carry that links successive bit
//   positions of a bit-serial LSB-first addition.
//   Ports:
//     clk      in  1  system clock, rising edge
//     reset_n  in  1  asynchronous active-low reset (carry <= 0)
//     a_bit    in  1  current operand A bit
//     b_bit    in  1  current operand B bit
//     clear    in  1  force carry to 0 (start of a new addition)
//     enable   in  1  register the carry-out of this bit position
//     sum_bit  out 1  sum of a_bit + b_bit + stored carry
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_slice
    import parking_count_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic a_bit,
    input  logic b_bit,
    input  logic clear,
    input  logic enable,
    output logic sum_bit
);
    logic carry_reg;
    logic carry_out;

    full_adder u_full_adder (
        .a    (a_bit),
        .b    (b_bit),
        .cin  (carry_reg),
        .sum  (sum_bit),
        .cout (carry_out)
    );

    // clear has priority so a new addition always starts with carry-in 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_reg <= 1'b0;
        end else if (clear) begin
            carry_reg <= 1'b0;
        end else if (enable) begin
            carry_reg <= carry_out;
        end
    end
endmodule

// File: rtl/parking_count_sequencer.sv
// ---------------------------------------------------------------------------
// parking_count_sequencer
//   Arbitrates +1 (entry gate) and -1 (exit gate) requests and applies them
//   to the occupancy count through one shared bit-serial adder, LSB first,
//   over WIDTH cycles. Reports full/empty and refuses INC when full and DEC
//   when empty, so the count never wraps.
//
//   Parameters:
//     WIDTH     counter width and number of serial add cycles (>= 1)
//     CAPACITY  number of spaces, 1 .. 2**WIDTH-1
//
//   Ports:
//     clk        in   1      system clock, rising edge
//     reset_n    in   1      asynchronous active-low reset
//     entry_req  in   1      level request +1, held until entry_ack
//     exit_req   in   1      level request -1, held until exit_ack
//     entry_ack  out  1      one-cycle completion pulse for entry
//     exit_ack   out  1      one-cycle completion pulse for exit
//     reject     out  1      with an ack: request refused, count unchanged
//     busy       out  1      high whenever the FSM is not IDLE
//     count      out  WIDTH  current occupancy
//     full       out  1      count == CAPACITY
//     empty      out  1      count == 0
//
//   Build option:
//     PARK_EXIT_PRIORITY_EN  defined   -> exit always wins a tie
//                            undefined -> round-robin tie-break
// ---------------------------------------------------------------------------
module parking_count_sequencer
    import parking_count_sequencer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CAPACITY = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             entry_ack,
    output logic             exit_ack,
    output logic             reject,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] CAP_VAL  = WIDTH'(CAPACITY);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    req_id_t          grant_reg;
    logic [WIDTH-1:0] count_reg;
    // Operand A is consumed from the LSB while sum bits enter at the MSB,
    // so after WIDTH shifts this register holds the result.
    logic [WIDTH-1:0] acc_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [CW-1:0]    bit_idx_reg;
    logic             entry_ack_reg;
    logic             exit_ack_reg;
    logic             reject_reg;
`ifndef PARK_EXIT_PRIORITY_EN
    req_id_t          rr_last_reg;
`endif

    logic             any_req;
    req_id_t          grant_next;
    op_t              op_next;
    logic             illegal_next;
    logic             sum_bit;
    logic [WIDTH-1:0] result_next;

    assign full  = (count_reg == CAP_VAL);
    assign empty = (count_reg == '0);
    assign busy  = (state_reg != IDLE);
    assign count     = count_reg;
    assign entry_ack = entry_ack_reg;
    assign exit_ack  = exit_ack_reg;
    assign reject    = reject_reg;

    // Arbiter: on a tie the requester not served last wins, or exit always
    // wins when the exit-priority build option is set.
    always_comb begin
        any_req    = entry_req | exit_req;
        grant_next = REQ_ENTRY;
        if (entry_req && exit_req) begin
`ifdef PARK_EXIT_PRIORITY_EN
            grant_next = REQ_EXIT;
`else
            grant_next = (rr_last_reg == REQ_EXIT) ? REQ_ENTRY : REQ_EXIT;
`endif
        end else if (exit_req) begin
            grant_next = REQ_EXIT;
        end
        op_next      = (grant_next == REQ_ENTRY) ? OP_INC : OP_DEC;
        illegal_next = (op_next == OP_INC) ? full : empty;
    end

    serial_add_slice u_serial_add_slice (
        .clk     (clk),
        .reset_n (reset_n),
        .a_bit   (acc_sr_reg[0]),
        .b_bit   (b_sr_reg[0]),
        .clear   (state_reg == IDLE),
        .enable  (state_reg == ADD),
        .sum_bit (sum_bit)
    );

    assign result_next = {sum_bit, acc_sr_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= REQ_ENTRY;
            count_reg     <= '0;
            acc_sr_reg    <= '0;
            b_sr_reg      <= '0;
            bit_idx_reg   <= '0;
            entry_ack_reg <= 1'b0;
            exit_ack_reg  <= 1'b0;
            reject_reg    <= 1'b0;
`ifndef PARK_EXIT_PRIORITY_EN
            rr_last_reg   <= REQ_EXIT;
`endif
        end else begin
            // Ack/reject are high only for the single DONE cycle.
            entry_ack_reg <= 1'b0;
            exit_ack_reg  <= 1'b0;
            reject_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg <= grant_next;
                        if (illegal_next) begin
                            // Refused request skips ADD; count untouched.
                            entry_ack_reg <= (grant_next == REQ_ENTRY);
                            exit_ack_reg  <= (grant_next == REQ_EXIT);
                            reject_reg    <= 1'b1;
`ifndef PARK_EXIT_PRIORITY_EN
                            rr_last_reg   <= grant_next;
`endif
                            state_reg     <= DONE;
                        end else begin
                            acc_sr_reg  <= count_reg;
                            // -1 is added as all-ones; the carry-out is dropped.
                            b_sr_reg    <= (op_next == OP_INC) ? WIDTH'(1) : '1;
                            bit_idx_reg <= '0;
                            state_reg   <= ADD;
                        end
                    end
                end
                ADD: begin
                    acc_sr_reg  <= result_next;
                    b_sr_reg    <= b_sr_reg >> 1;
                    bit_idx_reg <= bit_idx_reg + CW'(1);
                    if (bit_idx_reg == LAST_BIT) begin
                        count_reg     <= result_next;
                        entry_ack_reg <= (grant_reg == REQ_ENTRY);
                        exit_ack_reg  <= (grant_reg == REQ_EXIT);
`ifndef PARK_EXIT_PRIORITY_EN
                        rr_last_reg   <= grant_reg;
`endif
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
